// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants, FSM state encoding and IF/ID register
// layout for the instruction-fetch stage.
//   RESET_PC_DEF  : default PC loaded on reset
//   NOP_INSTR_DEF : bubble instruction (addi x0,x0,0)
//   fetch_state_e : S_BOOT=00, S_FETCH=01, S_HOLD=10, S_DRAIN=11
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10,
    S_DRAIN = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_unit.sv
// pc_unit: program counter register for the fetch stage.
//   clk, reset (async active-low)
//   advance  : step PC by 4 (wraps at 2^32 silently)
//   redirect : load word-aligned target; wins over advance
//   target   : redirect address (low two bits ignored)
//   pc       : current PC (always word aligned)
module pc_unit
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;

  // Select the next PC: redirect, sequential advance, or hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect) begin
      pc_next_s = word_align(target);
    end else if (advance) begin
      pc_next_s = pc_r + PC_STEP;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= word_align(RESET_PC);
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage. Owns the PC (via pc_unit), a
// req/rvalid instruction-memory master and the IF/ID pipeline register.
//   clk, reset (async active-low)
//   stall_IF                          : hold PC and IF/ID
//   branch_taken_EX, branch_target_EX : redirect + flush (beats stall)
//   imem_req, imem_addr               : fetch request, decoded from state
//   imem_rvalid, imem_rdata           : fetch response (may be same cycle)
//   instruction_ID, PC_ID, valid_ID   : IF/ID register outputs
// Optional build macro IF_PERF_COUNTERS_EN adds fetch_count / stall_count.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF,
  input  logic        branch_taken_EX,
  input  logic [31:0] branch_target_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_ID,
  output logic [31:0] PC_ID,
  output logic        valid_ID
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e state_r, state_next_s;
  ifid_t        ifid_r, ifid_next_s;
  logic [31:0]  hold_instr_r, hold_next_s;
  logic [31:0]  drain_addr_r, drain_next_s;
  logic [31:0]  pc_s;
  logic         advance_s;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance_s),
    .redirect (branch_taken_EX),
    .target   (branch_target_EX),
    .pc       (pc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a redirect outside S_DRAIN restarts fetching, but must
  // first drain a request the memory has not yet answered.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_BOOT:  state_next_s = S_FETCH;
      S_FETCH: state_next_s = (imem_rvalid && stall_IF) ? S_HOLD : S_FETCH;
      S_HOLD:  state_next_s = stall_IF ? S_HOLD : S_FETCH;
      S_DRAIN: state_next_s = imem_rvalid ? S_FETCH : S_DRAIN;
      default: state_next_s = S_BOOT;
    endcase
    if (branch_taken_EX && (state_r != S_DRAIN)) begin
      state_next_s = ((state_r == S_FETCH) && !imem_rvalid) ? S_DRAIN : S_FETCH;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // FSM outputs: request and address decoded from the current state.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_s;
    case (state_r)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_s;
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_r;
      end
      S_BOOT, S_HOLD: begin
        imem_req  = 1'b0;
        imem_addr = pc_s;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_s;
      end
    endcase
  end

  // IF/ID, hold-buffer and drain-address next values plus PC advance.
  always_comb begin
    ifid_next_s  = ifid_r;
    hold_next_s  = hold_instr_r;
    drain_next_s = drain_addr_r;
    advance_s    = 1'b0;
    if (branch_taken_EX) begin
      ifid_next_s = '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};
      hold_next_s = NOP_INSTR;
      // Remember the outstanding address only when entering S_DRAIN.
      if ((state_r == S_FETCH) && !imem_rvalid) begin
        drain_next_s = pc_s;
      end else begin
        drain_next_s = drain_addr_r;
      end
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_rvalid && !stall_IF) begin
            ifid_next_s = '{instr: imem_rdata, pc: pc_s, valid: 1'b1};
            advance_s   = 1'b1;
          end else if (imem_rvalid) begin
            hold_next_s = imem_rdata;
          end else if (!stall_IF) begin
            ifid_next_s = '{instr: NOP_INSTR, pc: ifid_r.pc, valid: 1'b0};
          end else begin
            ifid_next_s = ifid_r;
          end
        end
        S_HOLD: begin
          if (!stall_IF) begin
            ifid_next_s = '{instr: hold_instr_r, pc: pc_s, valid: 1'b1};
            advance_s   = 1'b1;
          end else begin
            ifid_next_s = ifid_r;
          end
        end
        S_DRAIN: begin
          if (!stall_IF) begin
            ifid_next_s = '{instr: NOP_INSTR, pc: ifid_r.pc, valid: 1'b0};
          end else begin
            ifid_next_s = ifid_r;
          end
        end
        S_BOOT: begin
          ifid_next_s = ifid_r;
        end
        default: begin
          ifid_next_s = ifid_r;
        end
      endcase
    end
  end

  // IF/ID pipeline register, hold buffer and drain address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_r       <= '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};
      hold_instr_r <= NOP_INSTR;
      drain_addr_r <= 32'h0000_0000;
    end else begin
      ifid_r       <= ifid_next_s;
      hold_instr_r <= hold_next_s;
      drain_addr_r <= drain_next_s;
    end
  end

  assign instruction_ID = ifid_r.instr;
  assign PC_ID          = ifid_r.pc;
  assign valid_ID       = ifid_r.valid;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count_r, stall_count_r;

  // Performance counters: valid IF/ID loads and stalled cycles, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_r <= 32'h0000_0000;
      stall_count_r <= 32'h0000_0000;
    end else begin
      fetch_count_r <= advance_s ? (fetch_count_r + 32'h0000_0001) : fetch_count_r;
      stall_count_r <= stall_IF ? (stall_count_r + 32'h0000_0001) : stall_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall_IF;
  logic        branch_taken_EX;
  logic [31:0] branch_target_EX;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_ID;
  logic [31:0] PC_ID;
  logic        valid_ID;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_IF         (stall_IF),
    .branch_taken_EX  (branch_taken_EX),
    .branch_target_EX (branch_target_EX),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instruction_ID   (instruction_ID),
    .PC_ID            (PC_ID),
    .valid_ID         (valid_ID)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetch_count      (fetch_count),
    .stall_count      (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two fixed words at 0 and 4, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00a0_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic v);
    chk({tag, "_instr"}, instruction_ID, ins);
    chk({tag, "_pc"}, PC_ID, pc);
    chk({tag, "_valid"}, 32'(valid_ID), 32'(v));
  endtask

  logic [31:0] exp_pc, p_addr, p_tgt, p_instr, p_pc;
  logic        p_req, p_rv, p_stall, p_br, p_val;
  int          wait_cnt, lat, n_deliv;

  initial begin
    reset = 1'b0; stall_IF = 1'b0; branch_taken_EX = 1'b0;
    branch_target_EX = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) tick();
    // reset state
    chk_ifid("rst", NOP, 32'h0, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    chk("boot_req", 32'(imem_req), 32'd0);
    tick();
    // 1: zero-wait fetch of 0 and 4
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(imem_addr); tick();
    chk_ifid("t1_w0", 32'h0050_0093, 32'h0, 1'b1);
    chk("t1_addr4", imem_addr, 32'h4);
    imem_rdata = mem_word(imem_addr); tick();
    chk_ifid("t1_w1", 32'h00a0_0113, 32'h4, 1'b1);
    chk("t1_addr8", imem_addr, 32'h8);
    // 2: three stall cycles, the word at 8 parks in the hold buffer
    stall_IF = 1'b1; imem_rdata = mem_word(imem_addr); tick();
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk_ifid("t2_frz0", 32'h00a0_0113, 32'h4, 1'b1);
    imem_rvalid = 1'b0;
    tick(); chk_ifid("t2_frz1", 32'h00a0_0113, 32'h4, 1'b1);
    tick(); chk_ifid("t2_frz2", 32'h00a0_0113, 32'h4, 1'b1);
    chk("t2_hold_req2", 32'(imem_req), 32'd0);
    stall_IF = 1'b0; tick();
    chk_ifid("t2_rel", mem_word(32'h8), 32'h8, 1'b1);
    chk("t2_addr12", imem_addr, 32'hC);
    // 3: redirect during stall, misaligned target
    stall_IF = 1'b1; branch_taken_EX = 1'b1; branch_target_EX = 32'h0000_0102;
    imem_rvalid = 1'b1; imem_rdata = mem_word(imem_addr); tick();
    chk_ifid("t3_flush", NOP, 32'h0, 1'b0);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req", 32'(imem_req), 32'd1);
    stall_IF = 1'b0;
    // 4: redirect with a request pending at 16 -> drain
    branch_target_EX = 32'h10; imem_rdata = mem_word(imem_addr); tick();
    branch_taken_EX = 1'b0; imem_rvalid = 1'b0;
    chk("t4_addr16", imem_addr, 32'h10);
    tick();
    chk("t4_wait_addr", imem_addr, 32'h10);
    branch_taken_EX = 1'b1; branch_target_EX = 32'h40; tick();
    branch_taken_EX = 1'b0;
    chk("t4_drain_addr", imem_addr, 32'h10);
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk_ifid("t4_drain", NOP, 32'h0, 1'b0);
    tick();
    chk("t4_drain_addr2", imem_addr, 32'h10);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h10); tick();
    chk("t4_new_addr", imem_addr, 32'h40);
    chk_ifid("t4_discard", NOP, 32'h0, 1'b0);
    imem_rdata = mem_word(imem_addr); tick();
    chk_ifid("t4_first", mem_word(32'h40), 32'h40, 1'b1);
    // PC wrap
    branch_taken_EX = 1'b1; branch_target_EX = 32'hFFFF_FFFE;
    imem_rdata = mem_word(imem_addr); tick();
    branch_taken_EX = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = mem_word(imem_addr); tick();
    chk("wrap_pc_id", PC_ID, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'h0);
    // 5: reset mid-request
    imem_rvalid = 1'b0; tick();
    reset = 1'b0; #1;
    chk_ifid("t5_rst_req", NOP, 32'h0, 1'b0);
    chk("t5_req0", 32'(imem_req), 32'd0);
    tick(); reset = 1'b1;
    chk("t5_boot", 32'(imem_req), 32'd0);
    tick();
    chk("t5_restart", imem_addr, 32'h0);
    // reset mid-S_HOLD
    stall_IF = 1'b1; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0); tick();
    chk("t5_hold_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b0; reset = 1'b0; #1;
    chk_ifid("t5_rst_hold", NOP, 32'h0, 1'b0);
    chk("t5_req1", 32'(imem_req), 32'd0);
    tick(); reset = 1'b1; stall_IF = 1'b0; tick();
    chk("t5_restart2", imem_addr, 32'h0);
    chk("t5_restart_req", 32'(imem_req), 32'd1);
`ifdef IF_PERF_COUNTERS_EN
    // 6: 10 fetches then 4 stall cycles since the last reset
    imem_rvalid = 1'b1;
    repeat (10) begin imem_rdata = mem_word(imem_addr); tick(); end
    imem_rvalid = 1'b0; stall_IF = 1'b1;
    repeat (4) tick();
    stall_IF = 1'b0;
    chk("t6_fetch_count", fetch_count, 32'd10);
    chk("t6_stall_count", stall_count, 32'd4);
`endif

    // Random phase: scoreboard of the in-order delivered stream.
    reset = 1'b0; imem_rvalid = 1'b0; stall_IF = 1'b0; branch_taken_EX = 1'b0;
    tick(); reset = 1'b1;
    exp_pc = 32'h0; n_deliv = 0; wait_cnt = 0; lat = $urandom_range(0, 2);
    p_req = 1'b0; p_rv = 1'b0; p_stall = 1'b0; p_br = 1'b0;
    p_addr = 32'h0; p_tgt = 32'h0; p_instr = NOP; p_pc = 32'h0; p_val = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      stall_IF = ($urandom_range(0, 3) == 0);
      branch_taken_EX = ($urandom_range(0, 19) == 0);
      branch_target_EX = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom_range(0, 4095));
      if (imem_req && (wait_cnt >= lat)) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(imem_addr);
        wait_cnt = 0; lat = $urandom_range(0, 2);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        if (imem_req) wait_cnt++;
      end
      p_req = imem_req; p_addr = imem_addr; p_rv = imem_rvalid;
      p_stall = stall_IF; p_br = branch_taken_EX; p_tgt = branch_target_EX;
      p_instr = instruction_ID; p_pc = PC_ID; p_val = valid_ID;
      tick();
      if (p_req && !p_rv) begin
        chk("rnd_req_stable", 32'(imem_req), 32'd1);
        chk("rnd_addr_stable", imem_addr, p_addr);
      end
      if (p_br) begin
        chk_ifid("rnd_flush", NOP, 32'h0, 1'b0);
        exp_pc = {p_tgt[31:2], 2'b00};
      end else if (p_stall) begin
        chk_ifid("rnd_stall_hold", p_instr, p_pc, p_val);
      end else if (valid_ID) begin
        chk("rnd_deliv_pc", PC_ID, exp_pc);
        chk("rnd_deliv_instr", instruction_ID, mem_word(exp_pc));
        exp_pc = exp_pc + 32'h4;
        n_deliv++;
      end
    end
    chk("rnd_progress", 32'(n_deliv > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
